// File: rtl/equiv_stim_driver_if.sv
// Stimulus/compare bus between equiv_stim_driver and the equivalence harness.
//   start        run request from the harness
//   y_1, y_2     91-bit outputs of the two candidate implementations
//   wire0..wire4 shared stimulus fed to both implementations
//   busy, done   run status (RUN/DRAIN vs. DONE)
//   fail         sticky mismatch flag for the current run
//   fail_idx     vector index of the first mismatch
// master = stimulus driver side, slave = harness side.
interface equiv_stim_driver_if #(
  parameter int CNT_W = 16
);
  logic                    start;
  logic [90:0]             y_1;
  logic [90:0]             y_2;
  logic [20:0]             wire0;
  logic [7:0]              wire1;
  logic [11:0]             wire2;
  logic signed [17:0]      wire3;
  logic signed [19:0]      wire4;
  logic                    busy;
  logic                    done;
  logic                    fail;
  logic [CNT_W-1:0]        fail_idx;

  modport master (
    input  start, y_1, y_2,
    output wire0, wire1, wire2, wire3, wire4, busy, done, fail, fail_idx
  );

  modport slave (
    output start, y_1, y_2,
    input  wire0, wire1, wire2, wire3, wire4, busy, done, fail, fail_idx
  );
endinterface

// File: rtl/equiv_stim_driver.sv
// Self-checking stimulus source for an equivalence harness. Three 32-bit
// LFSRs build a 79-bit vector per cycle that is split onto wire0..wire4; the
// two implementation outputs are compared LATENCY cycles later and the first
// mismatching vector index is latched.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  equiv_stim_driver_if.master (start, y_1/y_2 in; stimulus and status out)
module equiv_stim_driver #(
  parameter logic [31:0] SEED         = 32'hACE1_2468,
  parameter int          NUM_VECTORS  = 1024,
  parameter int          LATENCY      = 0,
  parameter int          CNT_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  equiv_stim_driver_if.master bus
);

  localparam int NLFSR = 3;
  // [2]=A, [1]=B, [0]=C so that {A,B,C} is the natural packed order.
  localparam logic [NLFSR-1:0][31:0] SEEDS =
    {SEED, SEED ^ 32'h5555_5555, SEED ^ 32'hAAAA_AAAA};
  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(NUM_VECTORS + LATENCY - 1);
  localparam logic [CNT_W-1:0] LAT      = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  state_t                     state;
  logic [CNT_W-1:0]           cyc;
  // lfsr always holds the state for the *next* vector; stim holds the
  // vector currently on the bus.
  logic [NLFSR-1:0][31:0]     lfsr, lfsr_nxt, seed_nxt;
  logic [78:0]                stim;
  logic                       busy_q, done_q, fail_q;
  logic [CNT_W-1:0]           fidx_q;
  logic                       in_win, mism;

  for (genvar i = 0; i < NLFSR; i++) begin : g_lfsr
    assign lfsr_nxt[i] = lfsr_step(lfsr[i]);
    assign seed_nxt[i] = lfsr_step(SEEDS[i]);
  end

  // Warm-up cycles 0..L-1 carry pipeline garbage and are never compared.
  if (LATENCY == 0) begin : g_win0
    assign in_win = 1'b1;
  end else begin : g_win
    assign in_win = (cyc >= LAT);
  end

  assign mism = in_win && (bus.y_1 != bus.y_2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cyc    <= '0;
      lfsr   <= SEEDS;
      stim   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      fidx_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            cyc    <= '0;
            stim   <= {SEEDS[2][14:0], SEEDS[1], SEEDS[0]};
            lfsr   <= seed_nxt;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            fidx_q <= '0;
          end
        end
        RUN, DRAIN: begin
          cyc <= cyc + 1'b1;
          if (mism && !fail_q) begin
            fail_q <= 1'b1;
            fidx_q <= cyc - LAT;
          end
          if ((STOP_ON_FAIL && mism) || cyc == LAST_CYC) begin
            // stimulus freezes on the vector of the final cycle
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (cyc == LAST_RUN) begin
            state <= DRAIN;
          end else if (state == RUN) begin
            stim <= {lfsr[2][14:0], lfsr[1], lfsr[0]};
            lfsr <= lfsr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wire0    = stim[78:58];
  assign bus.wire1    = stim[57:50];
  assign bus.wire2    = stim[49:38];
  assign bus.wire3    = $signed(stim[37:20]);
  assign bus.wire4    = $signed(stim[19:0]);
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fail     = fail_q;
  assign bus.fail_idx = fidx_q;

endmodule

// File: tb/tb_equiv_stim_driver.sv
// Bench for equiv_stim_driver: three instances (N=16/L=0, N=16/L=2,
// N=100/L=0 stop-on-fail) fed by pass-through or registered reference models.
module tb_equiv_stim_driver;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  start = '0, flip = '0, garb = '0;
  logic [90:0] y1 [3];
  logic [90:0] y2 [3];
  logic [78:0] vo [3];
  logic [2:0]  busy_o, done_o, fail_o;
  logic [15:0] fidx [3];
  logic [78:0] vec [100];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    equiv_stim_driver_if #(.CNT_W(16)) bus ();
    equiv_stim_driver #(
      .SEED(SEED), .NUM_VECTORS(g == 2 ? 100 : 16), .LATENCY(g == 1 ? 2 : 0),
      .CNT_W(16), .STOP_ON_FAIL(g == 2)
    ) u_dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.start  = start[g];
    assign bus.y_1    = y1[g];
    assign bus.y_2    = y2[g];
    assign vo[g]      = {bus.wire0, bus.wire1, bus.wire2, bus.wire3, bus.wire4};
    assign busy_o[g]  = bus.busy;
    assign done_o[g]  = bus.done;
    assign fail_o[g]  = bus.fail;
    assign fidx[g]    = bus.fail_idx;
    if (g == 1) begin : g_reg
      // two-stage registered implementations, garbage-able on y_2
      logic [78:0] p1, p2;
      always @(posedge clk) begin
        p1 <= vo[g];
        p2 <= p1;
      end
      assign y1[g] = {12'd0, p2};
      assign y2[g] = garb[g] ? ~{12'd0, p2} : {12'd0, p2};
    end else begin : g_pass
      assign y1[g] = {12'd0, vo[g]};
      assign y2[g] = {12'd0, vo[g]} ^ {90'd0, flip[g]};
    end
  end

  task automatic chk(input string nm, input logic [78:0] act, input logic [78:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic int nv(input int i);
    return (i == 2) ? 100 : 16;
  endfunction

  function automatic int lat(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  // Reference vectors straight from the LFSR rule.
  initial begin
    logic [31:0] a, b, c;
    a = SEED; b = SEED ^ 32'h5555_5555; c = SEED ^ 32'hAAAA_AAAA;
    for (int k = 0; k < 100; k++) begin
      vec[k] = {a[14:0], b, c};
      a = step(a); b = step(b); c = step(c);
    end
  end

  // Run model: phase 0 idle, 1 busy, 2 done; mk = cycle index in the run,
  // mvi = index of the vector expected on the bus (-1 = reset zeros).
  int mph [3] = '{0, 0, 0};
  int mk  [3] = '{0, 0, 0};
  int mvi [3] = '{-1, -1, -1};
  int midx[3] = '{0, 0, 0};
  bit mfail[3] = '{0, 0, 0};

  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mph[i] = 0; mk[i] = 0; mvi[i] = -1; mfail[i] = 0; midx[i] = 0;
      end else if (mph[i] != 1 && start[i]) begin
        mph[i] = 1; mk[i] = 0; mvi[i] = 0; mfail[i] = 0; midx[i] = 0;
      end else if (mph[i] == 1) begin
        if (mk[i] >= lat(i) && y1[i] != y2[i] && !mfail[i]) begin
          mfail[i] = 1;
          midx[i] = mk[i] - lat(i);
          if (i == 2) mph[i] = 2;
        end
        if (mph[i] == 1) begin
          mk[i]++;
          if (mk[i] < nv(i)) mvi[i] = mk[i];
          if (mk[i] == nv(i) + lat(i)) mph[i] = 2;
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", i), 79'(busy_o[i]), 79'(mph[i] == 1));
        chk($sformatf("done%0d", i), 79'(done_o[i]), 79'(mph[i] == 2));
        chk($sformatf("fail%0d", i), 79'(fail_o[i]), 79'(mfail[i]));
        chk($sformatf("fail_idx%0d", i), 79'(fidx[i]), 79'(midx[i]));
        chk($sformatf("vec%0d", i), vo[i], (mvi[i] < 0) ? 79'd0 : vec[mvi[i]]);
      end
    end
  end

  task automatic go(input int i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst busy", 79'(busy_o[i]), 79'd0);
      chk("rst done", 79'(done_o[i]), 79'd0);
      chk("rst fail", 79'(fail_o[i]), 79'd0);
      chk("rst fail_idx", 79'(fidx[i]), 79'd0);
      chk("rst wires", vo[i], 79'd0);
    end
    // model pins: hand-computed vectors 0 and 1
    chk("model v0 wire0", 79'(vec[0][78:58]), 79'h091A3E);
    chk("model v1 wire0", 79'(vec[1][78:58]), 79'h12343C);
    @(posedge clk); #1;
    rst = 1'b0;
    adv(1);

    // pass-through run, N=16 L=0
    go(0);
    chk("c0 wire0", 79'(vo[0][78:58]), 79'h091A3E);
    chk("c0 wire1", 79'(vo[0][57:50]), 79'h6D);
    chk("c0 wire4", 79'(vo[0][19:0]), 79'hB8EC2);
    chk("c0 busy", 79'(busy_o[0]), 79'd1);
    adv(1);
    chk("c1 wire0", 79'(vo[0][78:58]), 79'h12343C);
    chk("c1 wire4", 79'(vo[0][19:0]), 79'h71D85);
    adv(14);
    chk("c15 busy", 79'(busy_o[0]), 79'd1);
    chk("c15 done", 79'(done_o[0]), 79'd0);
    adv(1);
    chk("c16 busy", 79'(busy_o[0]), 79'd0);
    chk("c16 done", 79'(done_o[0]), 79'd1);
    chk("c16 fail", 79'(fail_o[0]), 79'd0);

    // single-bit flips at cycles 5 and 9
    go(0);
    adv(5);
    chk("c5 fail before", 79'(fail_o[0]), 79'd0);
    flip[0] = 1'b1;
    adv(1);
    flip[0] = 1'b0;
    chk("c6 fail", 79'(fail_o[0]), 79'd1);
    chk("c6 fail_idx", 79'(fidx[0]), 79'd5);
    adv(3);
    flip[0] = 1'b1;
    adv(1);
    flip[0] = 1'b0;
    chk("c10 fail_idx", 79'(fidx[0]), 79'd5);
    adv(6);
    chk("flip done", 79'(done_o[0]), 79'd1);
    chk("flip final idx", 79'(fidx[0]), 79'd5);

    // L=2 with garbage on y_2 during warm-up
    garb[1] = 1'b1;
    go(1);
    adv(2);
    garb[1] = 1'b0;
    adv(15);
    chk("L2 c17 busy", 79'(busy_o[1]), 79'd1);
    chk("L2 c17 done", 79'(done_o[1]), 79'd0);
    adv(1);
    chk("L2 c18 done", 79'(done_o[1]), 79'd1);
    chk("L2 c18 busy", 79'(busy_o[1]), 79'd0);
    chk("L2 fail", 79'(fail_o[1]), 79'd0);

    // stop-on-fail, N=100, mismatch at cycle 7
    go(2);
    adv(7);
    flip[2] = 1'b1;
    adv(1);
    flip[2] = 1'b0;
    chk("stop c8 done", 79'(done_o[2]), 79'd1);
    chk("stop c8 busy", 79'(busy_o[2]), 79'd0);
    chk("stop fail", 79'(fail_o[2]), 79'd1);
    chk("stop fail_idx", 79'(fidx[2]), 79'd7);
    adv(3);
    chk("stop hold done", 79'(done_o[2]), 79'd1);
    go(2);
    chk("restart fail", 79'(fail_o[2]), 79'd0);
    chk("restart wire0", 79'(vo[2][78:58]), 79'h091A3E);
    adv(100);
    chk("restart done", 79'(done_o[2]), 79'd1);
    chk("restart fail end", 79'(fail_o[2]), 79'd0);

    // reset mid-run with start held high while busy
    start[0] = 1'b1;
    adv(1);
    adv(6);
    chk("held c6 busy", 79'(busy_o[0]), 79'd1);
    chk("held c6 wire0", 79'(vo[0][78:58]), 79'(vec[6][78:58]));
    adv(1);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", 79'(busy_o[0]), 79'd0);
    chk("arst done", 79'(done_o[0]), 79'd0);
    chk("arst fail", 79'(fail_o[0]), 79'd0);
    chk("arst fail_idx", 79'(fidx[0]), 79'd0);
    chk("arst wires", vo[0], 79'd0);
    start[0] = 1'b0;
    adv(1);
    rst = 1'b0;
    adv(2);
    chk("post-rst idle busy", 79'(busy_o[0]), 79'd0);
    chk("post-rst idle done", 79'(done_o[0]), 79'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
